// File: rtl/bwn_word_serializer_if.sv
// Handshake bundle between the BWN row producer and the word serializer.
// The serializer uses the slave modport; the producer/consumer side uses master.
interface bwn_word_serializer_if #(
    parameter int WL = 8,
    parameter int N  = 4,
    parameter int IW = 2
);
    logic            iSTART;
    logic            iLOAD;
    logic [N*WL-1:0] iDATA;
    logic            iREADY;
    logic [WL-1:0]   oDATA;
    logic            oVALID;
    logic [IW-1:0]   oIDX;
    logic            oBUSY;
    logic            oDONE;

    modport master (
        output iSTART, iLOAD, iDATA, iREADY,
        input  oDATA, oVALID, oIDX, oBUSY, oDONE
    );

    modport slave (
        input  iSTART, iLOAD, iDATA, iREADY,
        output oDATA, oVALID, oIDX, oBUSY, oDONE
    );
endinterface

// File: rtl/bwn_word_serializer.sv
// Captures a row of N words in one cycle and streams them out lowest word first
// over a valid/ready handshake; iSTART aborts and clears any row in flight.
module bwn_word_serializer #(
    parameter int WL = 8,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    bwn_word_serializer_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          stateR;
    logic [N*WL-1:0] rowR;
    logic [IW-1:0]   idxR;
    logic [WL-1:0]   dataR;
    logic            validR;
    logic            doneR;

    logic            handshakeS;
    logic [IW-1:0]   nextIdxS;

    assign handshakeS = validR & bus.iREADY;
    assign nextIdxS   = idxR + IW'(1);

    // oDATA is kept as its own register so it always equals rowR[idxR] without a read mux on the output
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateR <= IDLE;
            rowR   <= '0;
            idxR   <= '0;
            dataR  <= '0;
            validR <= 1'b0;
            doneR  <= 1'b0;
        end else if (bus.iSTART) begin
            stateR <= IDLE;
            rowR   <= '0;
            idxR   <= '0;
            dataR  <= '0;
            validR <= 1'b0;
            doneR  <= 1'b0;
        end else begin
            doneR <= 1'b0;
            case (stateR)
                IDLE: begin
                    if (bus.iLOAD) begin
                        rowR   <= bus.iDATA;
                        idxR   <= '0;
                        dataR  <= bus.iDATA[WL-1:0];
                        validR <= 1'b1;
                        stateR <= SEND;
                    end
                end
                SEND: begin
                    if (handshakeS) begin
                        if (idxR == IW'(N - 1)) begin
                            // Row complete: back to IDLE showing word 0 of the finished row
                            stateR <= IDLE;
                            idxR   <= '0;
                            dataR  <= rowR[WL-1:0];
                            validR <= 1'b0;
                            doneR  <= 1'b1;
                        end else begin
                            idxR  <= nextIdxS;
                            dataR <= rowR[int'(nextIdxS)*WL +: WL];
                        end
                    end
                end
                default: begin
                    stateR <= IDLE;
                    idxR   <= '0;
                    dataR  <= rowR[WL-1:0];
                    validR <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oDATA  = dataR;
    assign bus.oVALID = validR;
    assign bus.oIDX   = idxR;
    assign bus.oBUSY  = validR;
    assign bus.oDONE  = doneR;

endmodule

// File: doc/bwn_word_serializer.md
# bwn_word_serializer

Parallel-to-serial unload stage for the BWN datapath. Captures a full row of N result words in one cycle, then streams them out one word per handshake on a valid/ready interface, lowest word first. It sits downstream of the per-lane result registers and feeds the narrow output path. A synchronous start/clear aborts any transfer in progress.

## Interface
- WL, 8, width of one word in bits
- N, 4, words per row (N ≥ 1)
- IW, 2, index width; must satisfy 2^IW ≥ N (use 1 when N = 1)

Ports:
- iCLK  input  1  system clock, all state updates on rising edge
- iRST  input  1  asynchronous, active-high reset
- iSTART  input  1  synchronous clear/abort, highest priority after iRST
- iLOAD  input  1  capture request for iDATA
- iDATA  input  N*WL  row to capture; word i = iDATA[i*WL +: WL]
- iREADY  input  1  downstream accepts oDATA this cycle
- oDATA  output  WL  current word
- oVALID  output  1  oDATA is valid
- oIDX  output  IW  index of the word on oDATA
- oBUSY  output  1  a row is held and not yet fully sent
- oDONE  output  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, SEND.
- Internal buffer: N×WL row register, index counter (IW bits).
- IDLE: oVALID=0, oBUSY=0. iLOAD=1 → capture iDATA into buffer, index←0, go to SEND.
- SEND: oVALID=1, oBUSY=1, oDATA=buffer[index], oIDX=index.
  - Handshake = oVALID & iREADY at rising edge.
  - Handshake with index<N-1 → index←index+1, stay in SEND.
  - Handshake with index=N-1 → go to IDLE, index←0, oDONE←1 for exactly one cycle.
  - iREADY=0 → index, oDATA and oVALID hold unchanged (no word dropped or repeated).
  - iLOAD in SEND is ignored; the buffer does not change mid-row.
- iSTART=1, any state → state IDLE, buffer←0, index←0, oDONE←0. iSTART overrides iLOAD and any handshake in the same cycle; the aborted row is discarded and oDONE does not pulse.
- oDONE is registered; during its pulse the FSM is already in IDLE, and iLOAD in that cycle is accepted.
- N=1: one handshake completes the row and pulses oDONE.
- oDATA is driven from the buffer at all times. In IDLE it shows buffer[0], which is 0 after reset or iSTART. Consumers qualify oDATA with oVALID.

## Timing
- Reset values: oDATA=0, oVALID=0, oIDX=0, oBUSY=0, oDONE=0, state IDLE, buffer all 0.
- iLOAD sampled at edge k → oVALID=1 with word 0 from cycle k+1 (one-cycle load latency).
- With iREADY held high: words 0..N-1 appear in cycles k+1..k+N. oDONE=1 in cycle k+N+1, with oVALID=0 in that cycle.
- Back-to-back rows: iLOAD asserted during the oDONE cycle gives the next row's word 0 one cycle later. There is one bubble cycle between rows.
- oVALID never deasserts in SEND until the last handshake. oVALID does not depend combinationally on iREADY.
- iRST is asynchronous: all outputs reach their reset values immediately, independent of iCLK.

## Test plan
- Reset then idle (WL=8, N=4): after iRST pulse, hold iLOAD=0 → oVALID=0, oBUSY=0, oDONE=0, oDATA=0 for 10 cycles.
- Streaming: iDATA=32'h44332211, iLOAD one cycle, iREADY=1 → oDATA 11,22,33,44 on consecutive cycles with oIDX 0..3. oDONE pulses once on the following cycle, then oBUSY=0.
- Backpressure: same row, iREADY=0 for 3 cycles while word 1 (22) is shown → oDATA=22 and oIDX=1 held, oVALID=1. After iREADY returns high, 22 is accepted once, followed by 33 and 44.
- Load while busy: while SEND is on word 0, assert iLOAD with iDATA=32'hDDCCBBAA → output still 11,22,33,44. After oDONE, reload 32'hDDCCBBAA in the oDONE cycle → AA appears on the next cycle.
- Abort: iSTART asserted during word 2 with iLOAD=1 and iREADY=1 in the same cycle → next cycle oVALID=0, oBUSY=0, oDATA=0, and no oDONE pulse ever occurs for that row.
- Async reset mid-row: assert iRST between clock edges during word 1 → all outputs go to reset values before the next edge, and the FSM resumes in IDLE.
